// File: rtl/lanzones_pkg.sv
// lanzones_pkg: shared types and constants for the lanzones instruction memory.
//   imem_state_t : loader/fetch FSM state encoding
//   LZ_NOP       : instruction returned for out-of-range fetches (addi x0,x0,0)
//   LZ_XLEN      : core address/data width
//   lz_oob()     : true when a word address lies beyond a 2^aw-word memory
package lanzones_pkg;

   localparam int unsigned LZ_XLEN = 32;
   localparam logic [LZ_XLEN-1:0] LZ_NOP = 32'h0000_0013;

   typedef enum logic [1:0] {
      LOAD = 2'd0,
      IDLE = 2'd1,
      READ = 2'd2,
      RESP = 2'd3
   } imem_state_t;

   // Shifting instead of slicing [31:aw] keeps this legal for any aw up to
   // the full address width (a shift by the width yields zero).
   function automatic logic lz_oob(input logic [LZ_XLEN-1:0] addr,
                                   input int unsigned aw);
      return (addr >> aw) != '0;
   endfunction

endpackage

// File: rtl/lanzones_imem_ram.sv
// lanzones_imem_ram: simple dual-port instruction RAM, 2^AW x 32, no reset.
//   clk          : clock, rising edge
//   we/waddr/wdata : synchronous write port
//   re/raddr     : synchronous read request
//   rdata        : read data, updated on the edge after re=1, held otherwise
module lanzones_imem_ram
   import lanzones_pkg::*;
#(
   parameter int AW = 8
) (
   input  logic               clk,
   input  logic               we,
   input  logic [AW-1:0]      waddr,
   input  logic [LZ_XLEN-1:0] wdata,
   input  logic               re,
   input  logic [AW-1:0]      raddr,
   output logic [LZ_XLEN-1:0] rdata
);

   logic [LZ_XLEN-1:0] mem [2**AW];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   always_ff @(posedge clk) begin
      if (re) rdata <= mem[raddr];
   end

endmodule

// File: rtl/lanzones_imem.sv
// lanzones_imem: instruction memory and loader in front of the core fetch stage.
//   clk, rst                 : clock (rising edge), async active-high reset
//   ld_we/ld_addr/ld_wdata   : host program writes, honoured only in LOAD
//   ld_go                    : pulse, LOAD -> IDLE (start serving the core)
//   ld_halt                  : pulse, back to LOAD once any fetch in flight ends
//   RRdy/RAddr               : core fetch request (level, held until RVld)
//   RVld/RData               : one-cycle fetch response
//   LEn                      : core run enable, low only in LOAD
//   fetch_cnt                : RVld pulses since reset (wrapping)
//   oob_err/ld_err           : sticky out-of-range fetch / illegal write flags
module lanzones_imem
   import lanzones_pkg::*;
#(
   parameter int                 AW       = 8,
   parameter logic [LZ_XLEN-1:0] NOP_WORD = LZ_NOP
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               ld_we,
   input  logic [AW-1:0]      ld_addr,
   input  logic [LZ_XLEN-1:0] ld_wdata,
   input  logic               ld_go,
   input  logic               ld_halt,
   input  logic               RRdy,
   input  logic [LZ_XLEN-1:0] RAddr,
   output logic               RVld,
   output logic [LZ_XLEN-1:0] RData,
   output logic               LEn,
   output logic [LZ_XLEN-1:0] fetch_cnt,
   output logic               oob_err,
   output logic               ld_err
);

   imem_state_t        state, state_n;
   logic [LZ_XLEN-1:0] addr_q;
   logic               oob_q;
   logic               rdata_ok;
   logic               halt_pend;
   logic               ram_we;
   logic               ram_re;
   logic               oob_d;
   logic [LZ_XLEN-1:0] ram_rdata;

   assign ram_we = ld_we && (state == LOAD);
   assign ram_re = (state == READ);
   assign oob_d  = lz_oob(addr_q, AW);

   lanzones_imem_ram #(.AW(AW)) u_ram (
      .clk   (clk),
      .we    (ram_we),
      .waddr (ld_addr),
      .wdata (ld_wdata),
      .re    (ram_re),
      .raddr (addr_q[AW-1:0]),
      .rdata (ram_rdata)
   );

   // Next-state logic. A halt in IDLE beats a simultaneous request; a halt
   // seen during a fetch is deferred through halt_pend until RESP.
   always_comb begin
      state_n = state;
      unique case (state)
         LOAD: if (ld_go) state_n = IDLE;
         IDLE: begin
            if (ld_halt)   state_n = LOAD;
            else if (RRdy) state_n = READ;
         end
         READ: state_n = RESP;
         RESP: state_n = (halt_pend || ld_halt) ? LOAD : IDLE;
         default: state_n = LOAD;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= LOAD;
      else     state <= state_n;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)                                        halt_pend <= 1'b0;
      else if (state_n == LOAD)                       halt_pend <= 1'b0;
      else if (ld_halt && (state == READ || state == RESP)) halt_pend <= 1'b1;
   end

   // Request capture and the out-of-range decision made in READ. oob_q stays
   // valid until the next READ so RData keeps showing the last response.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         addr_q   <= '0;
         oob_q    <= 1'b0;
         rdata_ok <= 1'b0;
      end else begin
         if (state == IDLE && state_n == READ) addr_q <= RAddr;
         if (state == READ) begin
            oob_q    <= oob_d;
            rdata_ok <= 1'b1;
         end
      end
   end

   // Outputs are flops decoded from the next state, so each one lines up with
   // the state it describes (RVld during RESP, LEn outside LOAD).
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         RVld      <= 1'b0;
         LEn       <= 1'b0;
         fetch_cnt <= '0;
         oob_err   <= 1'b0;
         ld_err    <= 1'b0;
      end else begin
         RVld <= (state_n == RESP);
         LEn  <= (state_n != LOAD);
         if (state == READ) begin
            fetch_cnt <= fetch_cnt + 1'b1;
            if (oob_d) oob_err <= 1'b1;
         end
         if (ld_we && state != LOAD) ld_err <= 1'b1;
      end
   end

   // The RAM read register is the data flop; only the select is added here.
   // rdata_ok hides the unreset RAM output until the first read completes,
   // giving RData a defined zero after reset.
   always_comb begin
      RData = '0;
      if (rdata_ok) RData = oob_q ? NOP_WORD : ram_rdata;
   end

endmodule

// File: tb/tb_lanzones_imem.sv
module tb_lanzones_imem;

   logic        clk = 1'b0;
   logic        rst;
   logic        ld_we;
   logic [7:0]  ld_addr;
   logic [31:0] ld_wdata;
   logic        ld_go;
   logic        ld_halt;
   logic        RRdy;
   logic [31:0] RAddr;
   logic        RVld;
   logic [31:0] RData;
   logic        LEn;
   logic [31:0] fetch_cnt;
   logic        oob_err;
   logic        ld_err;

   int vec  = 0;
   int errs = 0;
   logic [31:0] sb[$];
   logic [31:0] mem_model [256];
   bit          in_load;

   lanzones_imem #(.AW(8), .NOP_WORD(32'h0000_0013)) dut (
      .clk       (clk),
      .rst       (rst),
      .ld_we     (ld_we),
      .ld_addr   (ld_addr),
      .ld_wdata  (ld_wdata),
      .ld_go     (ld_go),
      .ld_halt   (ld_halt),
      .RRdy      (RRdy),
      .RAddr     (RAddr),
      .RVld      (RVld),
      .RData     (RData),
      .LEn       (LEn),
      .fetch_cnt (fetch_cnt),
      .oob_err   (oob_err),
      .ld_err    (ld_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vec++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] model_rd(input logic [31:0] a);
      return (a >= 32'd256) ? 32'h0000_0013 : mem_model[a[7:0]];
   endfunction

   // Scoreboard consumer: every response must match the oldest expected word.
   always @(negedge clk) begin
      if (!rst && RVld) begin
         if (sb.size() == 0) check("unexpected_rvld", {31'd0, RVld}, 32'd0);
         else                check("rdata", RData, sb.pop_front());
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // All drivers run at the negedge; the called-from step is always a negedge.
   task automatic load_word(input logic [7:0] a, input logic [31:0] d);
      ld_we = 1'b1; ld_addr = a; ld_wdata = d;
      if (in_load) mem_model[a] = d;
      @(negedge clk);
      ld_we = 1'b0;
   endtask

   task automatic go();
      ld_go = 1'b1;
      check("len_before_go", {31'd0, LEn}, 32'd0);
      @(negedge clk);
      ld_go = 1'b0;
      in_load = 1'b0;
      check("len_after_go", {31'd0, LEn}, 32'd1);
   endtask

   task automatic fetch(input logic [31:0] a, input string tag);
      int n = 0;
      sb.push_back(model_rd(a));
      RRdy = 1'b1; RAddr = a;
      do begin
         @(negedge clk);
         n++;
      end while (!RVld && n < 8);
      check({tag, "_latency"}, n, 32'd2);
      RRdy = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      rst = 1'b1; ld_we = 0; ld_addr = 0; ld_wdata = 0; ld_go = 0; ld_halt = 0;
      RRdy = 0; RAddr = 0; in_load = 1'b1;
      for (int i = 0; i < 256; i++) mem_model[i] = 32'hxxxx_xxxx;
      repeat (2) @(negedge clk);
      check("rst_len",   {31'd0, LEn},     32'd0);
      check("rst_rvld",  {31'd0, RVld},    32'd0);
      check("rst_rdata", RData,            32'd0);
      check("rst_cnt",   fetch_cnt,        32'd0);
      check("rst_oob",   {31'd0, oob_err}, 32'd0);
      check("rst_lderr", {31'd0, ld_err},  32'd0);
      rst = 1'b0;
      @(negedge clk);

      // Basic fetch
      load_word(8'd0, 32'h1234_5037);
      load_word(8'd1, 32'h0000_00B7);
      load_word(8'd2, 32'hDEAD_C137);
      load_word(8'd3, 32'h0000_0013);
      load_word(8'd5, 32'hA5A5_0005);
      go();
      for (int i = 0; i < 4; i++) fetch(i, "basic");
      check("basic_cnt", fetch_cnt, 32'd4);
      check("basic_oob_clear", {31'd0, oob_err}, 32'd0);

      // Out-of-range fetch
      fetch(32'h0000_0100, "oob");
      check("oob_flag", {31'd0, oob_err}, 32'd1);
      check("oob_cnt", fetch_cnt, 32'd5);

      // Write outside LOAD is dropped
      ld_we = 1'b1; ld_addr = 8'd5; ld_wdata = 32'hFFFF_FFFF;
      @(negedge clk);
      ld_we = 1'b0;
      check("lderr_flag", {31'd0, ld_err}, 32'd1);
      fetch(32'd5, "after_bad_write");
      check("rdata_hold", RData, 32'hA5A5_0005);
      check("rvld_pulse", {31'd0, RVld}, 32'd0);

      // Halt during a fetch (pulse in READ)
      sb.push_back(model_rd(32'd2));
      RRdy = 1'b1; RAddr = 32'd2;
      @(negedge clk);
      ld_halt = 1'b1;
      @(negedge clk);
      ld_halt = 1'b0;
      check("halt_rvld", {31'd0, RVld}, 32'd1);
      RRdy = 1'b0;
      @(negedge clk);
      in_load = 1'b1;
      check("halt_len", {31'd0, LEn}, 32'd0);
      RRdy = 1'b1; RAddr = 32'd0;
      repeat (4) begin
         @(negedge clk);
         check("load_ignores_rrdy", {31'd0, RVld}, 32'd0);
      end
      RRdy = 1'b0;
      check("halt_cnt", fetch_cnt, 32'd7);

      // Simultaneous halt and request in IDLE
      go();
      ld_halt = 1'b1; RRdy = 1'b1; RAddr = 32'd1;
      @(negedge clk);
      ld_halt = 1'b0; RRdy = 1'b0;
      in_load = 1'b1;
      check("simul_len", {31'd0, LEn}, 32'd0);
      repeat (3) @(negedge clk);
      check("simul_cnt", fetch_cnt, 32'd7);

      // Mid-fetch reset in RESP
      go();
      RRdy = 1'b1; RAddr = 32'd1;
      @(negedge clk);
      @(posedge clk);
      #2 rst = 1'b1;
      #1;
      check("mrst_rvld",  {31'd0, RVld},    32'd0);
      check("mrst_len",   {31'd0, LEn},     32'd0);
      check("mrst_cnt",   fetch_cnt,        32'd0);
      check("mrst_oob",   {31'd0, oob_err}, 32'd0);
      check("mrst_lderr", {31'd0, ld_err},  32'd0);
      RRdy = 1'b0;
      in_load = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      load_word(8'd1, 32'h0BAD_F00D);
      go();
      fetch(32'd1, "reload");
      fetch(32'd3, "persist");
      check("reload_cnt", fetch_cnt, 32'd2);

      repeat (2) @(negedge clk);
      check("sb_drained", sb.size(), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
      $finish;
   end

endmodule

// File: doc/lanzones_imem.md
# lanzones_imem

Instruction memory and loader that sits directly upstream of the lanzones core fetch stage. A host writes a program into an on-chip word-addressed RAM while the core is held off. On `ld_go` the block raises `LEn` and serves the core's `RRdy`/`RAddr` fetch requests, returning one `RVld`-qualified `RData` word per request. It also counts served fetches and flags out-of-range addresses.

## Interface
Parameters:
- `AW`, 8: RAM address width in words; depth is 2^AW.
- `NOP_WORD`, 32'h00000013: data returned for out-of-range fetches (`addi x0,x0,0`).

Ports:
- `clk`  in  1: the single clock, rising edge.
- `rst`  in  1: reset, asynchronous and active-high.
- `ld_we`  in  1: host write strobe; honoured only in LOAD.
- `ld_addr`  in  AW: host write word address.
- `ld_wdata`  in  32: host write data.
- `ld_go`  in  1: one-cycle pulse; LOAD to IDLE, starts serving.
- `ld_halt`  in  1: one-cycle pulse; returns to LOAD after any fetch in flight completes.
- `RRdy`  in  1: core fetch request; level, held until `RVld` is seen.
- `RAddr`  in  32: core fetch word address; valid while `RRdy`=1.
- `RVld`  out  1: fetch response valid, one-cycle pulse.
- `RData`  out  32: fetched instruction; valid only when `RVld`=1.
- `LEn`  out  1: core run enable; high in every state except LOAD.
- `fetch_cnt`  out  32: number of `RVld` pulses since reset, wraps at 2^32.
- `oob_err`  out  1: sticky; set on any fetch with `RAddr` ≥ 2^AW.
- `ld_err`  out  1: sticky; set on `ld_we` outside LOAD.

## Operation
- States: LOAD, IDLE, READ, RESP.
- **LOAD:**
  - `LEn`=0.
  - `ld_we`=1 writes `ld_wdata` to RAM[`ld_addr`].
  - `ld_go` moves to IDLE. If `ld_we` and `ld_go` arrive together, the write is performed and the state still moves.
- **IDLE:**
  - `RRdy`=1 captures `RAddr` and moves to READ.
  - `ld_halt`=1 moves to LOAD. If `ld_halt` and `RRdy` are both high, `ld_halt` wins and the request is ignored.
- **READ:**
  - Issues a synchronous RAM read of `RAddr[AW-1:0]`.
  - Computes `oob` = (`RAddr[31:AW]` ≠ 0).
  - Moves to RESP.
- **RESP:**
  - `RVld`=1; `RData` = RAM word, or `NOP_WORD` if `oob`.
  - `fetch_cnt` increments; `oob_err` is set if `oob`.
  - Next state is LOAD if a halt is pending, otherwise IDLE.
- **Halt while busy:** `ld_halt` seen in READ or RESP sets `halt_pend`. The fetch completes normally, then the block enters LOAD. `halt_pend` is cleared on entering LOAD.
- **Unexpected `RRdy`:** `RRdy` in LOAD is ignored, with no response.
- **Errors:** `ld_we` outside LOAD is dropped and sets `ld_err`.
- **`ld_go` outside LOAD:** ignored.
- **Sticky flags:** `ld_err` and `oob_err` clear only on `rst`.
- **Re-loading:** RAM contents persist across LOAD/IDLE cycles.

## Timing
- **Reset values:** state=LOAD, `LEn`=0, `RVld`=0, `RData`=0, `fetch_cnt`=0, `oob_err`=0, `ld_err`=0. RAM contents are not reset.
- **Registered outputs:** all outputs are registered; there is no combinational path from inputs to outputs.
- **`LEn` edges:** `LEn` rises in the cycle after the `ld_go` cycle, and falls in the cycle after the transition to LOAD.
- **Fetch latency:** if `RRdy` is sampled high in IDLE at the end of cycle c0, then c1 is READ and c2 is RESP with `RVld`=1. The latency is therefore 2 cycles, and the next request can be accepted at the end of c3 at the earliest.
- **`RRdy` drop:** the core de-asserts `RRdy` in response to `RVld`, so `RRdy` is low in c3. A new request in IDLE is accepted only on a fresh `RRdy`.
- **`RData` hold:** `RData` holds its last value when `RVld`=0.
- **Write-then-read:** a LOAD write at cycle n is readable by any fetch, since a fetch requires at least one cycle in IDLE first.
- **Mid-operation reset:** `rst` asserted in READ or RESP aborts the fetch. `RVld` drops immediately (asynchronous) and no count is taken.

## Structure
- **`lanzones_pkg`:**
  - state enum `imem_state_t` (LOAD, IDLE, READ, RESP);
  - constant `LZ_NOP` = 32'h00000013;
  - constant `LZ_XLEN` = 32.
- **`lanzones_imem_ram` sub-module:** simple dual-port RAM, 2^AW×32, with a synchronous write port (`we`, `waddr`, `wdata`) and a synchronous read port (`re`, `raddr`, `rdata`). It has no reset.
- **Top level:** contains the FSM, the address/oob capture registers, `halt_pend`, the counter and the sticky flags.

## Test plan
- **Basic fetch:** load RAM[0..3] = 0x12345037, 0x000000B7, 0xDEADC137, 0x00000013, pulse `ld_go`, then drive 4 core-style fetches of addresses 0..3. Required: `LEn`=1 one cycle after `ld_go`; each `RVld` two cycles after `RRdy` with the matching word; `fetch_cnt`=4.
- **Out-of-range fetch:** with AW=8, fetch `RAddr`=0x100. Required: `RData`=0x00000013, `oob_err`=1, `fetch_cnt` increments.
- **Halt during a fetch:** pulse `ld_halt` in the READ cycle. Required: `RVld` still pulses with the correct data, the block then enters LOAD, and `LEn`=0 on the next cycle. A subsequent `RRdy` gets no response.
- **Write outside LOAD:** pulse `ld_we` in IDLE to address 5 with 0xFFFFFFFF. Required: `ld_err`=1, and a later fetch of address 5 returns the original word.
- **Simultaneous halt and request:** assert `ld_halt` and `RRdy` together in IDLE. Required: no `RVld`, state goes to LOAD, `fetch_cnt` unchanged.
- **Mid-fetch reset:** assert `rst` in RESP. Required: `RVld`=0 immediately; `LEn`, `fetch_cnt` and both error flags = 0; re-load and re-fetch works.
